// File: rtl/array_output_drain.sv
// Output drain behind the systolic array: de-skews column results, writes aligned rows to memory.
// Optional DRAIN_RELU_EN clamps negative column values to zero before the output register.

module array_output_drain_lane #(
  parameter int DEPTH      = 1,
  parameter int ELEM_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_vld,
  input  logic [ELEM_WIDTH-1:0] i_data,
  output logic                  o_vld,
  output logic [ELEM_WIDTH-1:0] o_data
);
  logic [DEPTH-1:0]                 r_vld;
  logic [DEPTH-1:0][ELEM_WIDTH-1:0] r_data;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_vld  <= '0;
      r_data <= '0;
    end else begin
      r_vld[0]  <= i_vld;
      r_data[0] <= i_data;
      for (int k = 1; k < DEPTH; k++) begin
        r_vld[k]  <= r_vld[k-1];
        r_data[k] <= r_data[k-1];
      end
    end
  end

  assign o_vld  = r_vld[DEPTH-1];
  assign o_data = r_data[DEPTH-1];
endmodule

module array_output_drain #(
  parameter int WIDTH_HEIGHT = 16,
  parameter int ELEM_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 8,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic                             i_start,
  input  logic [ADDR_WIDTH-1:0]            i_base_addr,
  input  logic [CNT_WIDTH-1:0]             i_num_rows,
  input  logic [WIDTH_HEIGHT-1:0]          i_col_valid,
  input  logic [WIDTH_HEIGHT*ELEM_WIDTH-1:0] i_col_data,
  output logic                             o_wr_en,
  output logic [ADDR_WIDTH-1:0]            o_wr_addr,
  output logic [WIDTH_HEIGHT*ELEM_WIDTH-1:0] o_wr_data,
  output logic                             o_busy,
  output logic                             o_done,
  output logic                             o_skew_err,
  output logic                             o_overflow
);
  localparam int W  = WIDTH_HEIGHT;
  localparam int EW = ELEM_WIDTH;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DRAIN = 2'd1, S_DONE = 2'd2} state_t;

  state_t                 r_state, w_next;
  logic [W-1:0]           w_dvld;
  logic [W-1:0][EW-1:0]   w_ddata, w_row;
  logic                   w_row_ok, w_skew, w_accept, w_write;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [CNT_WIDTH-1:0]   r_rem;
  logic                   r_wr_en, r_done, r_skew, r_ovf;
  logic [ADDR_WIDTH-1:0]  r_wr_addr;
  logic [W-1:0][EW-1:0]   r_wr_data;

  // Column j lags column 0 by j cycles, so it needs W-1-j stages to line up with the last column.
  generate
    for (genvar j = 0; j < W; j++) begin : g_lane
      if (j == W-1) begin : g_tail
        assign w_dvld[j]  = i_col_valid[j];
        assign w_ddata[j] = i_col_data[j*EW +: EW];
      end else begin : g_dly
        array_output_drain_lane #(.DEPTH(W-1-j), .ELEM_WIDTH(EW)) u_lane (
          .i_clk   (i_clk),
          .i_reset (i_reset),
          .i_vld   (i_col_valid[j]),
          .i_data  (i_col_data[j*EW +: EW]),
          .o_vld   (w_dvld[j]),
          .o_data  (w_ddata[j])
        );
      end
`ifdef DRAIN_RELU_EN
      assign w_row[j] = w_ddata[j][EW-1] ? '0 : w_ddata[j];
`else
      assign w_row[j] = w_ddata[j];
`endif
    end
  endgenerate

  assign w_row_ok = &w_dvld;
  assign w_skew   = (|w_dvld) & ~(&w_dvld);

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_write  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_accept = 1'b1;
          w_next   = (i_num_rows == '0) ? S_DONE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_row_ok) begin
          w_write = 1'b1;
          if (r_rem == CNT_WIDTH'(1)) w_next = S_DONE;
        end
      end
      S_DONE: begin
        // Two cycles here: the first arms the done pulse, the second shows it.
        if (r_done) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_rem     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_done    <= 1'b0;
      r_skew    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wr_en <= w_write;
      r_done  <= (r_state == S_DONE) && !r_done;
      if (w_accept) begin
        r_addr <= i_base_addr;
        r_rem  <= i_num_rows;
        r_skew <= 1'b0;
        r_ovf  <= 1'b0;
      end else begin
        if (w_write) begin
          r_addr <= r_addr + 1'b1;
          r_rem  <= r_rem - 1'b1;
        end
        if (r_state == S_DRAIN && w_skew)   r_skew <= 1'b1;
        if (r_state == S_DONE  && w_row_ok) r_ovf  <= 1'b1;
      end
      if (w_write) begin
        r_wr_addr <= r_addr;
        r_wr_data <= w_row;
      end
    end
  end

  assign o_wr_en    = r_wr_en;
  assign o_wr_addr  = r_wr_addr;
  assign o_wr_data  = r_wr_data;
  assign o_busy     = (r_state != S_IDLE);
  assign o_done     = r_done;
  assign o_skew_err = r_skew;
  assign o_overflow = r_ovf;
endmodule

// File: doc/array_output_drain.md
Name: array_output_drain

Overview:
- Downstream neighbour of the systolic array top level; consumes the skewed per-column results leaving the bottom of the array.
- Per-column delay lines de-skew the results, so every column of one output row is aligned in the same cycle.
- Each aligned row is written as one word into output memory at consecutive addresses from a base address.
- Counts rows, flags skew and overflow errors, and pulses done when the programmed row count has been written.

Parameters:
- WIDTH_HEIGHT, 16, array dimension (number of output columns).
- ELEM_WIDTH, 16, bits per column result; two's complement.
- ADDR_WIDTH, 8, output memory address width.
- CNT_WIDTH, 8, width of the row counter and of num_rows.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a drain; accepted only in IDLE.
- base_addr  in  ADDR_WIDTH  first output address; latched on accepted start.
- num_rows  in  CNT_WIDTH  rows to write; latched on accepted start.
- col_valid  in  WIDTH_HEIGHT  per-column result valid; column j is skewed j cycles behind column 0.
- col_data  in  WIDTH_HEIGHT*ELEM_WIDTH  per-column results; column j occupies bits [j*ELEM_WIDTH +: ELEM_WIDTH].
- wr_en  out  1  output memory write enable.
- wr_addr  out  ADDR_WIDTH  output memory write address.
- wr_data  out  WIDTH_HEIGHT*ELEM_WIDTH  aligned row, same column packing as col_data.
- busy  out  1  high in DRAIN and DONE.
- done  out  1  one-cycle pulse on completion.
- skew_err  out  1  sticky: misaligned valids detected.
- overflow  out  1  sticky: valid row arrived after num_rows rows were written.

Behaviour:
- Reset (reset=0, asynchronous) clears:
  - all outputs to 0;
  - state to IDLE;
  - row counter, latched addr/count and all delay-line stages to 0.
- De-skew:
  - Column j passes through WIDTH_HEIGHT-1-j registers, carrying both data and valid; column WIDTH_HEIGHT-1 has no delay stage.
  - Delay lines shift every cycle in every state.
- Row detect: all de-skewed valid bits = 1. Skew error: de-skewed valid vector neither all-1 nor all-0.
- Output registers: wr_en, wr_addr and wr_data are registered.
  - If col_valid[0] is sampled high at edge E, wr_en/wr_data for that row are visible after edge E+WIDTH_HEIGHT-1.
  - Latency is WIDTH_HEIGHT-1 cycles.
- States:
  - IDLE:
    - On start: latch base_addr into addr and num_rows into remaining; clear skew_err and overflow.
    - Go to DONE if num_rows=0, else go to DRAIN.
    - Aligned rows arriving in IDLE are dropped silently; no flags are raised.
  - DRAIN, on each aligned row:
    - wr_en=1, wr_addr=addr, wr_data=row.
    - addr increments, wrapping modulo 2^ADDR_WIDTH.
    - remaining decrements.
    - When remaining reaches 0 after a write, go to DONE.
  - DRAIN, on misaligned valids: set skew_err, write nothing, counters unchanged.
  - DONE:
    - Assert done for exactly one cycle, then return to IDLE.
    - An aligned row arriving in DONE sets overflow and is not written.
    - Overflow is not detected in IDLE.
- Protocol rules:
  - start is ignored while busy=1; a start in the same cycle as the final write is ignored.
  - wr_en is never high in IDLE or DONE.
  - wr_en is high only one cycle per row; rows may arrive back-to-back, one per cycle, with no bubbles required.
- Reset asserted mid-drain aborts immediately: no done pulse, and partially written data stays in memory.

Optional Feature:
- Macro: DRAIN_RELU_EN.
- Defined: each ELEM_WIDTH column value is replaced with 0 when its sign bit is 1, before the output register. Latency is unchanged.
- Undefined: values pass through unmodified. No extra logic is present.

Test Plan:
- WIDTH_HEIGHT=4, start with base_addr=0x10, num_rows=3, feed 3 back-to-back correctly skewed rows (row r, column j = 16*r+j)
  -> writes at 0x10, 0x11, 0x12 on consecutive cycles;
  -> first wr_en 3 cycles after col_valid[0] is sampled;
  -> each row packed as column j = 16*r+j;
  -> done pulses in the cycle after the last write;
  -> busy falls one cycle after that.
- num_rows=0 start -> no wr_en; done pulses the cycle after start; busy high for exactly 2 cycles.
- base_addr=0xFE, num_rows=3 -> write addresses 0xFE, 0xFF, 0x00.
- Column 2 valid driven one cycle late on row 1 of 3
  -> skew_err set and held;
  -> row 1 not written;
  -> done waits for a third correctly skewed row;
  -> next start clears skew_err.
- num_rows=2, feed 3 rows -> 2 writes, the third row raises overflow; reset asserted mid-drain in a second run -> all outputs 0 asynchronously, no done pulse.
- DRAIN_RELU_EN defined, column value 0xFFF0 -> written as 0x0000 while a column value of 0x0010 is unchanged; undefined -> 0xFFF0 is written unchanged.
